i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'd100, 7-bit device address matched against the first received byte [7:1].
REQ-002 SHALL have parameter REG_AW, default 3, register-pointer width; register file depth = 2**REG_AW bytes.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on scl_in/sda_in (legal 2..4).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-006 SHALL have port scl_in  input  1  bus SCL level; asynchronous to clk.
REQ-007 SHALL have port sda_in  input  1  bus SDA level; asynchronous to clk.
REQ-008 SHALL have port sda_oe  output  1  open-drain enable; 1 = pull SDA low, 0 = release.
REQ-009 SHALL have port wr_valid  output  1  one-clk pulse when a written data byte is committed.
REQ-010 SHALL have port wr_addr  output  REG_AW  register index of the committed write; valid with wr_valid.
REQ-011 SHALL have port wr_data  output  8  byte committed; valid with wr_valid.
REQ-012 SHALL have port busy  output  1  high from a START addressed to this device until STOP or a return to IDLE.

Function
REQ-013 SHALL sample scl_in/sda_in through SYNC_STAGES flops; edge and condition detection uses synchronised values only; clk SHALL be at least 16x the SCL rate.
REQ-014 SHALL detect START (SDA fall while SCL high) and STOP (SDA rise while SCL high); a detected edge of SDA while SCL high is never treated as a data bit.
REQ-015 SHALL sample receive bits on the synchronised SCL rising edge, MSB first; SHALL update sda_oe only on the clk after a synchronised SCL falling edge.
REQ-016 SHALL implement states IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT_STOP.
REQ-017 SHALL go to DEV on START from any state, including repeated START mid-transfer; bit counter reset to 7.
REQ-018 DEV: after 8 bits, address match -> DEV_ACK with sda_oe=1 for the ninth SCL period; mismatch -> WAIT_STOP with sda_oe=0 throughout.
REQ-019 DEV_ACK with R/W=0 -> PTR; with R/W=1 -> RDAT, loading the byte at the current pointer into the shift register.
REQ-020 PTR: after 8 bits, pointer <= byte[REG_AW-1:0] (upper bits ignored), ACK, -> WDAT.
REQ-021 WDAT: after 8 bits, write reg[pointer], pulse wr_valid for exactly one clk with wr_addr=pointer, ACK, pointer increments modulo 2**REG_AW, -> WDAT.
REQ-022 RDAT: drive sda_oe = ~bit (MSB first) for 8 SCL periods, then release SDA in RDAT_ACK and sample master ACK.
REQ-023 RDAT_ACK: ACK (SDA=0) -> pointer increments modulo depth, next byte loaded, -> RDAT; NACK (SDA=1) -> WAIT_STOP with sda_oe=0.
REQ-024 SHALL wrap the pointer from 2**REG_AW-1 to 0 on both read and write auto-increment.
REQ-025 STOP in any state -> IDLE with sda_oe=0 on the next clk; an incomplete byte SHALL be discarded (no wr_valid, register unchanged).
REQ-026 SHALL keep the pointer across STOP/START so a write-pointer-then-repeated-START-read sequence reads from the set pointer.
REQ-027 wr_valid and a START/STOP detected in the same clk: wr_valid still pulses; the state follows the START/STOP.
REQ-028 wr_valid SHALL assert within 2 clk of the synchronised SCL rising edge sampling bit 0.

Reset
REQ-029 On rst: state IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, pointer=0, bit counter=7, register file all 8'h00; synchroniser flops preset to 1.
REQ-030 rst mid-transfer SHALL release SDA on the next clk and ignore the bus until the next START.

Verification
REQ-031 START, 0xC8, 0x02, 0xA5, 0x5A, STOP -> ACK on all four bytes; wr_valid pulses (2,0xA5) then (3,0x5A).
REQ-032 START, 0xC8, 0x03, repeated START, 0xC9, master ACK, NACK -> reads 0x5A then 0x00; SDA released after NACK; busy falls at STOP.
REQ-033 START, 0x90 (address 0x48) -> no ACK, sda_oe stays 0 until STOP; no wr_valid.
REQ-034 Pointer 7, write 0x11, 0x22 -> wr_valid (7,0x11) then (0,0x22) (wrap).
REQ-035 STOP after 4 bits of a data byte -> no wr_valid, register unchanged, state IDLE.
REQ-036 rst asserted while slave drives a read bit low -> sda_oe=0 next clk; next START, 0xC9 reads reg[0]=0x00.

Source files
------------

// File: rtl/i2c_reg_slave_if.sv
// i2c_reg_slave_if: bus and write-notification signals of the I2C register slave.
//   scl_in/sda_in : raw bus levels seen by the slave (asynchronous to clk)
//   sda_oe        : open-drain enable from the slave (1 = pull SDA low)
//   wr_valid      : one-clk pulse when a written byte is committed
//   wr_addr       : register index of the committed byte
//   wr_data       : committed byte
//   busy          : transfer addressed to this slave in progress
interface i2c_reg_slave_if #(
  parameter int unsigned REG_AW = 3
) ();
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic              wr_valid;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave exposing a small byte register file with an auto-incrementing pointer.
// A write transfer sets the pointer then writes bytes; a read transfer returns bytes from the
// pointer. SCL/SDA are oversampled on clk, so clk must run at least 16x the SCL rate.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : i2c_reg_slave_if slave modport (SCL/SDA in, SDA pull-down enable, write notification)
module i2c_reg_slave #(
  parameter logic [6:0]  DEV_ADDR    = 7'd100,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  i2c_reg_slave_if.slave bus
);
  localparam int unsigned Depth = 2 ** REG_AW;

  typedef enum logic [3:0] {
    StIdle, StDev, StDevAck, StPtr, StPtrAck, StWdat, StWdatAck, StRdat, StRdatAck, StWaitStop
  } state_e;

  // Synchronisers, preset to the idle bus level.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SDA edges only count as conditions while SCL was high on both samples.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [REG_AW-1:0] ptr_q;
  logic              rw_q;
  logic              ninth_q;  // ninth SCL rise of an ACK slot already seen
  logic              sda_oe_q, wr_valid_q, busy_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        regs_q [Depth];

  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {shift_q[6:0], sda_s};
  assign last_bit = (bit_cnt_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ninth_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int unsigned i = 0; i < Depth; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_valid_q <= 1'b0;
      // Commit is independent of START/STOP so a coincident condition cannot drop it.
      if (state_q == StWdat && scl_rise && last_bit) begin
        regs_q[ptr_q] <= rx_byte;
        wr_valid_q    <= 1'b1;
        wr_addr_q     <= ptr_q;
        wr_data_q     <= rx_byte;
      end

      if (start_det) begin
        state_q   <= StDev;
        bit_cnt_q <= 3'd7;
        ninth_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= 3'd7;
        ninth_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StDev, StPtr, StWdat: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              if (!last_bit) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end else begin
                bit_cnt_q <= 3'd7;
                if (state_q == StDev) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= StDevAck;
                    rw_q    <= rx_byte[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= StWaitStop;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == StPtr) begin
                  ptr_q   <= rx_byte[REG_AW-1:0];
                  state_q <= StPtrAck;
                end else begin
                  ptr_q   <= ptr_q + REG_AW'(1);
                  state_q <= StWdatAck;
                end
              end
            end
          end
          StDevAck, StPtrAck, StWdatAck: begin
            if (scl_rise) begin
              ninth_q <= 1'b1;
            end else if (scl_fall) begin
              if (!ninth_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                ninth_q   <= 1'b0;
                bit_cnt_q <= 3'd7;
                if (state_q == StDevAck && rw_q) begin
                  shift_q  <= regs_q[ptr_q];
                  sda_oe_q <= ~regs_q[ptr_q][7];
                  state_q  <= StRdat;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == StDevAck) ? StPtr : StWdat;
                end
              end
            end
          end
          StRdat: begin
            if (scl_rise) begin
              if (last_bit) begin
                state_q <= StRdatAck;
                ninth_q <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                shift_q   <= {shift_q[6:0], 1'b0};
              end
            end else if (scl_fall) begin
              sda_oe_q <= ~shift_q[7];
            end
          end
          StRdatAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ninth_q <= 1'b1;
                ptr_q   <= ptr_q + REG_AW'(1);
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= StWaitStop;
              end
            end else if (scl_fall) begin
              if (!ninth_q) begin
                sda_oe_q <= 1'b0;
              end else begin
                ninth_q   <= 1'b0;
                bit_cnt_q <= 3'd7;
                shift_q   <= regs_q[ptr_q];
                sda_oe_q  <= ~regs_q[ptr_q][7];
                state_q   <= StRdat;
              end
            end
          end
          StIdle, StWaitStop: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: directed bench for i2c_reg_slave; bit-banged I2C master, table of write
// transactions plus hand sequences for read, aborted byte and mid-read reset.
module tb_i2c_reg_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_reg_slave_if #(.REG_AW(3)) bus ();

  // Wired-AND bus: master level combined with the slave pull-down.
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_reg_slave #(.DEV_ADDR(7'd100), .REG_AW(3), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [10:0] wq[$];
  logic        oe_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.wr_valid) wq.push_back({bus.wr_addr, bus.wr_data});
    if (bus.sda_oe) oe_seen = 1'b1;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = bus.sda_in; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(~m_ack);
    sda_m = 1'b1;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [2:0] exp_a0;
    logic [2:0] exp_a1;
  } wvec_t;

  wvec_t vec[4];

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rd;

    vec[0] = '{8'hC8, 8'h02, 8'hA5, 8'h5A, 1'b1, 3'd2, 3'd3};
    vec[1] = '{8'hC8, 8'h07, 8'h11, 8'h22, 1'b1, 3'd7, 3'd0};
    vec[2] = '{8'hC8, 8'h0D, 8'h33, 8'h44, 1'b1, 3'd5, 3'd6};
    vec[3] = '{8'h90, 8'h01, 8'h77, 8'h88, 1'b0, 3'd0, 3'd0};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_busy", bus.busy, 0);
    wait_q();

    for (int v = 0; v < 4; v++) begin
      wq.delete();
      oe_seen = 1'b0;
      i2c_start();
      send_byte(vec[v].dev, ack);
      check($sformatf("v%0d_dev_ack", v), ack, vec[v].exp_ack);
      check($sformatf("v%0d_busy", v), bus.busy, vec[v].exp_ack);
      send_byte(vec[v].ptr, ack);
      check($sformatf("v%0d_ptr_ack", v), ack, vec[v].exp_ack);
      send_byte(vec[v].d0, ack);
      check($sformatf("v%0d_d0_ack", v), ack, vec[v].exp_ack);
      send_byte(vec[v].d1, ack);
      check($sformatf("v%0d_d1_ack", v), ack, vec[v].exp_ack);
      i2c_stop();
      wait_q();
      check($sformatf("v%0d_busy_end", v), bus.busy, 0);
      check($sformatf("v%0d_oe_seen", v), oe_seen, vec[v].exp_ack);
      check($sformatf("v%0d_wr_count", v), wq.size(), vec[v].exp_ack ? 2 : 0);
      if (vec[v].exp_ack && wq.size() == 2) begin
        check($sformatf("v%0d_wr0", v), wq[0], {vec[v].exp_a0, vec[v].d0});
        check($sformatf("v%0d_wr1", v), wq[1], {vec[v].exp_a1, vec[v].d1});
      end
    end

    // Read from pointer 3 after a repeated START: 0x5A then untouched reg 4.
    i2c_start();
    send_byte(8'hC8, ack);
    check("rd_dev_ack", ack, 1);
    send_byte(8'h03, ack);
    check("rd_ptr_ack", ack, 1);
    i2c_start();
    send_byte(8'hC9, ack);
    check("rd_devr_ack", ack, 1);
    recv_byte(1'b1, rd);
    check("rd_byte0", rd, 8'h5A);
    recv_byte(1'b0, rd);
    check("rd_byte1", rd, 8'h00);
    wait_q();
    check("rd_released", bus.sda_oe, 0);
    check("rd_busy_before_stop", bus.busy, 1);
    i2c_stop();
    wait_q();
    check("rd_busy_after_stop", bus.busy, 0);

    // Byte abandoned after four bits by a STOP.
    wq.delete();
    i2c_start();
    send_byte(8'hC8, ack);
    send_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    wait_q();
    check("abort_no_wr", wq.size(), 0);
    check("abort_busy", bus.busy, 0);
    i2c_start();
    send_byte(8'hC8, ack);
    send_byte(8'h01, ack);
    i2c_start();
    send_byte(8'hC9, ack);
    recv_byte(1'b0, rd);
    check("abort_reg1", rd, 8'h00);
    i2c_stop();
    wait_q();

    // Reset while the slave pulls SDA low for bit 6 of 0xA5.
    i2c_start();
    send_byte(8'hC8, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'hC9, ack);
    recv_bit(b);
    check("rstrd_bit7", b, 1);
    check("rstrd_driving", bus.sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrd_released", bus.sda_oe, 0);
    check("rstrd_busy", bus.busy, 0);
    wait_q();
    i2c_start();
    send_byte(8'hC9, ack);
    check("rstrd_dev_ack", ack, 1);
    recv_byte(1'b0, rd);
    check("rstrd_reg0", rd, 8'h00);
    i2c_stop();
    wait_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
